// File: rtl/mem_pkg.sv
//------------------------------------------------------------------
// mem_pkg : shared types and helpers for the memory stage
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_type_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  localparam int BYTES_PER_WORD = 4;

  // Type 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (typ == MEM_BYTE) begin
      mis = 1'b0;
    end else if (typ == MEM_HALF) begin
      mis = lo[0];
    end else begin
      mis = |lo;
    end
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align_unit.sv
//------------------------------------------------------------------
// mem_align_unit : byte enables, store lane steering, load extraction
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module mem_align_unit
  import mem_pkg::*;
(
  input  logic [1:0]                  i_type,
  input  logic                        i_sign,
  input  logic [1:0]                  i_addr_lo,
  input  logic [31:0]                 i_wdata,
  input  logic [31:0]                 i_rword,
  output logic [BYTES_PER_WORD-1:0]   o_be,
  output logic [31:0]                 o_wdata,
  output logic                        o_misalign,
  output logic [31:0]                 o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rword[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  end

  // Store data is replicated across lanes; the byte enable picks the live lanes.
  always_comb begin
    o_misalign = is_misaligned(i_type, i_addr_lo);
    o_be       = 4'b1111;
    o_wdata    = i_wdata;
    o_rdata    = i_rword;
    case (i_type)
      MEM_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
      end
      MEM_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sign & w_half[15]}}, w_half};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/memory_stage_lat.sv
//------------------------------------------------------------------
// memory_stage_lat : data RAM with multi-cycle access FSM and M->W register
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module memory_stage_lat
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 12,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid_i,
  input  logic                  MemReq_i,
  input  logic                  MemWrite_i,
  input  logic [1:0]            MemType_i,
  input  logic                  MemSign_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4M_i,
  output logic                  StallM_o,
  output logic                  MisalignM_o,
  output logic                  ValidW_o,
  output logic [DATA_WIDTH-1:0] ALUResultW_o,
  output logic [DATA_WIDTH-1:0] ReadDataW_o,
  output logic [DATA_WIDTH-1:0] PCPlus4W_o
);

  localparam int         c_IDX_W    = ADDR_BITS - 2;
  localparam int         c_WORDS    = 2 ** c_IDX_W;
  localparam logic       c_MULTI    = (LATENCY > 1) ? 1'b1 : 1'b0;
  localparam logic [3:0] c_CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  mem_state_e r_state;
  logic [3:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0] r_type;
  logic       r_sign;
  logic       r_write;

  logic [DATA_WIDTH-1:0] r_mem [c_WORDS];

  logic                      w_busy;
  logic                      w_memop;
  logic [DATA_WIDTH-1:0]     w_addr;
  logic [DATA_WIDTH-1:0]     w_wdata_in;
  logic [1:0]                w_type;
  logic                      w_sign;
  logic                      w_write;
  logic [c_IDX_W-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]     w_rword;
  logic [BYTES_PER_WORD-1:0] w_be;
  logic [DATA_WIDTH-1:0]     w_st_data;
  logic                      w_al_mis;
  logic [DATA_WIDTH-1:0]     w_ld_data;
  logic                      w_accept;
  logic                      w_start;
  logic                      w_complete;
  logic                      w_we;

  assign w_busy  = (r_state == BUSY);
  assign w_memop = Valid_i & MemReq_i;

  // While BUSY only the latched request drives the access path.
  assign w_addr     = w_busy ? r_addr  : ALUResultM_i;
  assign w_wdata_in = w_busy ? r_wdata : WriteDataM_i;
  assign w_type     = w_busy ? r_type  : MemType_i;
  assign w_sign     = w_busy ? r_sign  : MemSign_i;
  assign w_write    = w_busy ? r_write : MemWrite_i;

  assign w_idx   = w_addr[ADDR_BITS-1:2];
  assign w_rword = r_mem[w_idx];

  mem_align_unit u_align (
    .i_type     (w_type),
    .i_sign     (w_sign),
    .i_addr_lo  (w_addr[1:0]),
    .i_wdata    (w_wdata_in),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_st_data),
    .o_misalign (w_al_mis),
    .o_rdata    (w_ld_data)
  );

  assign MisalignM_o = w_memop & is_misaligned(MemType_i, ALUResultM_i[1:0]);

  assign w_accept   = ~w_busy & w_memop & ~w_al_mis;
  assign w_start    = w_accept & c_MULTI;
  assign w_complete = (w_accept & ~c_MULTI) | (w_busy & (r_cnt == 4'd0));
  assign w_we       = w_complete & w_write & ~rst;

  assign StallM_o = w_start | (w_busy & (r_cnt != 4'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_type  <= 2'b00;
      r_sign  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= BUSY;
            r_cnt   <= c_CNT_INIT;
            r_addr  <= ALUResultM_i;
            r_wdata <= WriteDataM_i;
            r_type  <= MemType_i;
            r_sign  <= MemSign_i;
            r_write <= MemWrite_i;
          end
        end
        default: begin
          if (r_cnt == 4'd0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ValidW_o     <= 1'b0;
      ALUResultW_o <= '0;
      ReadDataW_o  <= '0;
      PCPlus4W_o   <= '0;
    end else if (StallM_o) begin
      ValidW_o     <= 1'b0;
      ALUResultW_o <= '0;
      ReadDataW_o  <= '0;
      PCPlus4W_o   <= '0;
    end else begin
      ValidW_o     <= w_busy ? 1'b1 : Valid_i;
      ALUResultW_o <= w_addr;
      ReadDataW_o  <= (w_complete & ~w_write) ? w_ld_data : '0;
      PCPlus4W_o   <= PCPlus4M_i;
    end
  end

endmodule

`default_nettype wire

// File: doc/memory_stage_lat.md
Name: memory_stage_lat

Overview:
Parametrised successor to the current memory-stage wrapper. Contains a byte-addressable data RAM and a configurable-latency access FSM that stalls upstream stages while an access is in flight. Adds byte/half/word store lanes, load extraction with sign or zero extension, and misalignment detection. Registers the M->W pipeline boundary internally. Sits between the execute/memory pipeline register and the writeback mux; drives the hazard unit's memory stall input.

Parameters:
DATA_WIDTH, 32, datapath width; fixed at 32 for RV32 lane logic.
ADDR_BITS, 12, byte-address bits decoded; RAM holds 2^(ADDR_BITS-2) words.
LATENCY, 3, cycles per memory access; legal range 1..15.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
Valid_i  in  1  instruction valid in M stage
MemReq_i  in  1  instruction is a load or store (ignored unless Valid_i)
MemWrite_i  in  1  1 = store, 0 = load
MemType_i  in  2  00 byte, 01 half, 10 word; 11 treated as word
MemSign_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend
ALUResultM_i  in  32  byte address / ALU result
WriteDataM_i  in  32  store data, right-aligned
PCPlus4M_i  in  32  PC+4 passthrough
StallM_o  out  1  hold M and earlier stages this cycle
MisalignM_o  out  1  combinational misaligned-access flag for current M op
ValidW_o  out  1  registered instruction valid
ALUResultW_o  out  32  registered ALUResultM_i
ReadDataW_o  out  32  registered extended load data; 0 for non-loads
PCPlus4W_o  out  32  registered PCPlus4M_i

Behaviour:
- Reset:
  - FSM -> IDLE; counter -> 0.
  - All W outputs -> 0, including ValidW_o = 0.
  - RAM contents are not reset.
  - Reset during BUSY aborts the access: the pending store is not written.
  - rst takes priority over every other input.
- Access definition:
  - A mem-op is Valid_i & MemReq_i.
  - An op is misaligned if it is a half with addr[0] = 1, or a word (or type 11) with addr[1:0] != 0.
  - MisalignM_o = mem-op & misaligned. It is purely combinational and independent of FSM state.
- Misaligned op:
  - No stall, no RAM write.
  - Completes at the next edge with ReadDataW_o = 0 and ValidW_o = 1.
- Non-mem or invalid op:
  - Registers to W at the next edge; ReadDataW_o = 0.
  - StallM_o = 0.
- FSM states: IDLE and BUSY.
  - IDLE, aligned mem-op, LATENCY = 1: completes at this edge; no stall.
  - IDLE, aligned mem-op, LATENCY > 1: StallM_o = 1 combinationally in the accept cycle. Latch address, data, type and sign. Load counter with LATENCY-2 and go to BUSY.
  - BUSY, counter != 0: StallM_o = 1; decrement the counter.
  - BUSY, counter == 0: StallM_o = 0. At this edge the access completes and the FSM returns to IDLE.
  - Total stall is LATENCY-1 cycles per access.
- Input stability: upstream holds M inputs stable while StallM_o = 1. The block uses only the latched copies during BUSY.
- W register during a stall: W outputs load a bubble (ValidW_o = 0, data 0) on every edge where StallM_o = 1.
- Completion edge, store (little-endian):
  - Write only the enabled byte lanes of word addr[ADDR_BITS-1:2].
  - Byte: lane addr[1:0] <- WriteData[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} <- WriteData[15:0].
  - Word: all four lanes.
- Completion edge, load:
  - Read the word, extract the byte or half by address, extend per MemSign_i, and register into ReadDataW_o.
- Back-to-back ops: a mem-op presented in the cycle after completion is accepted from IDLE normally, so there is no dead cycle between accesses.
- Address range: address bits above ADDR_BITS are ignored, so addresses alias (wrap) modulo 2^ADDR_BITS.

Decomposition:
- Shared package mem_pkg:
  - mem_type_e enum: MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10.
  - mem_state_e enum: IDLE, BUSY.
  - Constant BYTES_PER_WORD = 4.
- Sub-module mem_align_unit (combinational), which generates:
  - the 4-bit byte-enable,
  - the shifted store data,
  - the misalign flag,
  - the extracted and extended load value.

Test Plan:
1. LATENCY=3. Store word 0xDEADBEEF to 0x010, then load word from 0x010 -> StallM_o high for exactly 2 cycles on each op; ReadDataW_o = 0xDEADBEEF with ValidW_o = 1 on the completing edge; ValidW_o = 0 during stalls.
2. Store byte 0x80 to 0x013 over word 0x00000000 -> load word reads 0x80000000; load byte signed from 0x013 -> 0xFFFFFF80; load byte unsigned -> 0x00000080.
3. Store half 0xABCD to 0x022 -> load word from 0x020 reads 0xABCD0000; load half signed from 0x022 -> 0xFFFFABCD.
4. Load word from 0x011 and load half from 0x021 -> MisalignM_o = 1, no stall, ReadDataW_o = 0, RAM contents unchanged.
5. Store word 0x12345678 to 0x030; assert rst in the first BUSY cycle; load from 0x030 -> old value returned, and all W outputs are 0 in the cycle after reset.
6. LATENCY=1 build. Alternate store and load every cycle -> StallM_o never asserts; each load returns the value stored in the previous cycle; address 0x1010 aliases to 0x010.
